// File: rtl/ej32_dstack.sv
// ----------------------------------------------------------------------------
// ej32_dstack - parametrised data-stack engine for the eJ32 core.
//
// TOS and NOS live in registers (t_q, s_q). Deeper entries spill into a
// register array mem[0..DEPTH-3] whose fill level is sp = max(depth-2, 0).
// One stack opcode is executed per enabled cycle. Illegal ops are rejected
// without any state change and raise sticky overflow/underflow flags.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-low
//   en       in   operation enable (0 = hold all state)
//   op       in   0 NOP, 1 PUSH, 2 POP, 3 SWAP, 4 REPL, 5 POPREPL, 6 DUP, 7 OVER
//   din      in   data for PUSH / REPL / POPREPL
//   clr_err  in   clears the sticky error flags on the next edge
//   t_o      out  top of stack
//   s_o      out  next on stack
//   depth_o  out  number of valid entries, 0..DEPTH
//   empty_o  out  depth_o == 0
//   full_o   out  depth_o == DEPTH
//   ovf_o    out  sticky overflow flag
//   unf_o    out  sticky underflow flag
//   err_o    out  combinational: the op presented this cycle is rejected
// ----------------------------------------------------------------------------
module ej32_dstack #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] din,
  input  logic           clr_err,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] s_o,
  output logic [CW-1:0]  depth_o,
  output logic           empty_o,
  output logic           full_o,
  output logic           ovf_o,
  output logic           unf_o,
  output logic           err_o
);

  localparam int MD = DEPTH - 2;                     // spill entries
  localparam int AW = (MD > 1) ? $clog2(MD) : 1;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] THREE   = CW'(3);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_SWAP    = 3'd3,
    OP_REPL    = 3'd4,
    OP_POPREPL = 3'd5,
    OP_DUP     = 3'd6,
    OP_OVER    = 3'd7
  } op_e;

  op_e            op_c;
  logic [DSZ-1:0] mem [MD];
  logic [DSZ-1:0] t_q, t_d, s_q, s_d;
  logic [CW-1:0]  depth_q, depth_d;
  logic           ovf_q, unf_q;
  logic           ovf_set, unf_set;
  logic           mem_we;
  logic [CW-1:0]  wr_ptr, rd_ptr;
  logic [DSZ-1:0] rd_data;
  logic           ge1, ge2, ge3, full_c;

  assign op_c   = op_e'(op);
  assign ge1    = (depth_q >= ONE);
  assign ge2    = (depth_q >= TWO);
  assign ge3    = (depth_q >= THREE);
  assign full_c = (depth_q == DEPTH_C);

  // Spill slot sp = depth-2 on a push, refill slot sp-1 = depth-3 on a pop.
  // Both are only used under the matching depth guard, so they never underflow
  // where they matter.
  assign wr_ptr  = depth_q - TWO;
  assign rd_ptr  = depth_q - THREE;
  assign rd_data = ge3 ? mem[rd_ptr[AW-1:0]] : '0;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    t_d     = t_q;
    s_d     = s_q;
    depth_d = depth_q;
    mem_we  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op_c)
        OP_PUSH, OP_DUP, OP_OVER: begin
          if (full_c)                       ovf_set = 1'b1;
          else if (op_c == OP_DUP  && !ge1) unf_set = 1'b1;
          else if (op_c == OP_OVER && !ge2) unf_set = 1'b1;
          else begin
            t_d     = (op_c == OP_DUP)  ? t_q :
                      (op_c == OP_OVER) ? s_q : din;
            s_d     = t_q;
            mem_we  = ge2;                  // NOS spills only if it is valid
            depth_d = depth_q + ONE;
          end
        end
        OP_POP: begin
          if (!ge1) unf_set = 1'b1;
          else begin
            t_d     = ge2 ? s_q : '0;
            s_d     = rd_data;
            depth_d = depth_q - ONE;
          end
        end
        OP_SWAP: begin
          if (!ge2) unf_set = 1'b1;
          else begin
            t_d = s_q;
            s_d = t_q;
          end
        end
        OP_REPL: begin
          if (!ge1) unf_set = 1'b1;
          else      t_d = din;
        end
        OP_POPREPL: begin
          if (!ge2) unf_set = 1'b1;
          else begin
            t_d     = din;
            s_d     = rd_data;
            depth_d = depth_q - ONE;
          end
        end
        default: ;                          // OP_NOP
      endcase
    end
  end

  assign err_o = ovf_set | unf_set;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q     <= '0;
      s_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      s_q     <= s_d;
      depth_q <= depth_d;
      // A new error wins over a simultaneous clear.
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      unf_q   <= unf_set | (unf_q & ~clr_err);
    end
  end

  // NOTE: the spill array is deliberately not reset; depth gates every read,
  // so stale contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (mem_we && rst) mem[wr_ptr[AW-1:0]] <= s_q;
  end

  assign t_o     = t_q;
  assign s_o     = s_q;
  assign depth_o = depth_q;
  assign empty_o = (depth_q == '0);
  assign full_o  = full_c;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_ej32_dstack.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ej32_dstack. Instance u_big uses the
// default parameters (DEPTH=64); u_small uses DEPTH=4 for the overflow cases.
// Both share clock, reset, op, din and clr_err; each has its own enable.
// ----------------------------------------------------------------------------
module tb_ej32_dstack;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, SWAP = 3'd3,
                         REPL = 3'd4, POPREPL = 3'd5, DUP = 3'd6, OVER = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [2:0]  op = NOP;
  logic [31:0] din = '0;
  logic        clr_err = 1'b0;

  logic [31:0] t_a, s_a, t_b, s_b;
  logic [6:0]  depth_a;
  logic [2:0]  depth_b;
  logic        empty_a, full_a, ovf_a, unf_a, err_a;
  logic        empty_b, full_b, ovf_b, unf_b, err_b;

  logic        err_s;                        // err_o captured before the edge
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ej32_dstack u_big (
    .clk(clk), .rst(rst), .en(en_a), .op(op), .din(din), .clr_err(clr_err),
    .t_o(t_a), .s_o(s_a), .depth_o(depth_a), .empty_o(empty_a),
    .full_o(full_a), .ovf_o(ovf_a), .unf_o(unf_a), .err_o(err_a)
  );

  ej32_dstack #(.DSZ(32), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .en(en_b), .op(op), .din(din), .clr_err(clr_err),
    .t_o(t_b), .s_o(s_b), .depth_o(depth_b), .empty_o(empty_b),
    .full_o(full_b), .ovf_o(ovf_b), .unf_o(unf_b), .err_o(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op to the selected instance (sel=1 -> u_small) for one cycle.
  task automatic issue(input bit sel, input logic [2:0] o,
                       input logic [31:0] d, input logic c);
    @(negedge clk);
    op = o; din = d; clr_err = c;
    en_a = ~sel; en_b = sel;
    #1 err_s = sel ? err_b : err_a;
    @(posedge clk);
    #1;
    en_a = 1'b0; en_b = 1'b0; op = NOP; clr_err = 1'b0;
  endtask

  logic [31:0] t_m, s_m, pt, ps, d;

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("rst_t",     t_a, 32'h0);
    check("rst_s",     s_a, 32'h0);
    check("rst_depth", 32'(depth_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full",  32'(full_a),  32'd0);
    check("rst_ovf",   32'(ovf_a),   32'd0);
    check("rst_unf",   32'(unf_a),   32'd0);
    @(negedge clk); rst = 1'b1;

    // ---------------- basic push / pop ----------------
    issue(0, PUSH, 32'h11, 0);
    issue(0, PUSH, 32'h22, 0);
    issue(0, PUSH, 32'h33, 0);
    check("push3_t", t_a, 32'h33);
    check("push3_s", s_a, 32'h22);
    check("push3_depth", 32'(depth_a), 32'd3);
    issue(0, POP, 0, 0);
    check("pop1_t", t_a, 32'h22);
    check("pop1_d", 32'(depth_a), 32'd2);
    issue(0, POP, 0, 0);
    check("pop2_t", t_a, 32'h11);
    check("pop2_d", 32'(depth_a), 32'd1);
    issue(0, POP, 0, 0);
    check("pop3_t", t_a, 32'h0);
    check("pop3_d", 32'(depth_a), 32'd0);
    check("pop3_empty", 32'(empty_a), 32'd1);
    check("pop3_err", 32'(err_s), 32'd0);

    // ---------------- underflow ----------------
    issue(0, POP, 0, 0);
    check("unf_pop_err", 32'(err_s), 32'd1);
    check("unf_pop_flag", 32'(unf_a), 32'd1);
    check("unf_pop_depth", 32'(depth_a), 32'd0);
    issue(0, PUSH, 32'h7, 0);
    issue(0, SWAP, 0, 0);
    check("unf_swap_err", 32'(err_s), 32'd1);
    check("unf_swap_flag", 32'(unf_a), 32'd1);
    check("unf_swap_t", t_a, 32'h7);
    check("unf_swap_d", 32'(depth_a), 32'd1);
    issue(0, POP, 0, 0);
    issue(0, POP, 0, 1);                     // clear and new error together
    check("unf_clr_prio", 32'(unf_a), 32'd1);
    issue(0, NOP, 0, 1);
    check("unf_cleared", 32'(unf_a), 32'd0);
    check("nop_err", 32'(err_s), 32'd0);

    // ---------------- SWAP / OVER / POPREPL / DUP / REPL ----------------
    issue(0, PUSH, 32'd10, 0);
    issue(0, PUSH, 32'd20, 0);
    issue(0, PUSH, 32'd30, 0);
    issue(0, SWAP, 0, 0);
    check("swap_t", t_a, 32'd20);
    check("swap_s", s_a, 32'd30);
    issue(0, OVER, 0, 0);
    check("over_t", t_a, 32'd30);
    check("over_s", s_a, 32'd20);
    check("over_d", 32'(depth_a), 32'd4);
    issue(0, POPREPL, 32'd50, 0);
    check("poprepl_t", t_a, 32'd50);
    check("poprepl_s", s_a, 32'd30);
    check("poprepl_d", 32'(depth_a), 32'd3);
    issue(0, DUP, 0, 0);
    check("dup_t", t_a, 32'd50);
    check("dup_s", s_a, 32'd50);
    check("dup_d", 32'(depth_a), 32'd4);
    issue(0, REPL, 32'h99, 0);
    check("repl_t", t_a, 32'h99);
    check("repl_d", 32'(depth_a), 32'd4);
    // Stack is now 10,30,50,0x99: pops must refill from the spill array.
    issue(0, POP, 0, 0);
    check("drain1_t", t_a, 32'd50);
    check("drain1_s", s_a, 32'd30);
    issue(0, POP, 0, 0);
    check("drain2_t", t_a, 32'd30);
    check("drain2_s", s_a, 32'd10);
    issue(0, POP, 0, 0);
    check("drain3_t", t_a, 32'd10);
    check("drain3_s", s_a, 32'd0);
    issue(0, POP, 0, 0);

    // ---------------- push/pop streaming at depth DEPTH-2 ----------------
    for (int i = 0; i < 62; i++) issue(0, PUSH, 32'h1000 + i, 0);
    check("fill_depth", 32'(depth_a), 32'd62);
    t_m = 32'h1000 + 61;
    s_m = 32'h1000 + 60;
    for (int i = 0; i < 50; i++) begin
      pt = t_m; ps = s_m;
      d = $urandom;
      issue(0, PUSH, d, 0);
      s_m = t_m; t_m = d;
      check("stream_push_t", t_a, t_m);
      check("stream_push_s", s_a, s_m);
      issue(0, POP, 0, 0);
      t_m = pt; s_m = ps;
      check("stream_pop_t", t_a, t_m);
      check("stream_pop_s", s_a, s_m);
    end
    check("stream_depth", 32'(depth_a), 32'd62);
    issue(0, PUSH, 32'hC1, 0);
    issue(0, PUSH, 32'hC2, 0);
    check("big_full", 32'(full_a), 32'd1);
    issue(0, DUP, 0, 0);
    check("big_ovf_err", 32'(err_s), 32'd1);
    check("big_ovf_t", t_a, 32'hC2);

    // ---------------- overflow on DEPTH=4 ----------------
    for (int i = 1; i <= 4; i++) issue(1, PUSH, 32'(i), 0);
    check("small_full", 32'(full_b), 32'd1);
    check("small_depth", 32'(depth_b), 32'd4);
    issue(1, PUSH, 32'd5, 0);
    check("small_ovf_err", 32'(err_s), 32'd1);
    check("small_ovf_flag", 32'(ovf_b), 32'd1);
    check("small_ovf_t", t_b, 32'd4);
    check("small_ovf_d", 32'(depth_b), 32'd4);
    issue(1, NOP, 0, 1);
    check("small_ovf_clr", 32'(ovf_b), 32'd0);
    issue(1, POP, 0, 0);
    issue(1, POP, 0, 0);
    check("small_pop_t", t_b, 32'd2);
    check("small_pop_s", s_b, 32'd1);

    // ---------------- reset mid-operation ----------------
    @(negedge clk); rst = 1'b0; #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) issue(0, PUSH, 32'h50 + i, 0);
    check("pre_rst_depth", 32'(depth_a), 32'd5);
    @(negedge clk);
    op = PUSH; din = 32'hEE; en_a = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrst_t", t_a, 32'h0);
    check("midrst_s", s_a, 32'h0);
    check("midrst_depth", 32'(depth_a), 32'd0);
    check("midrst_empty", 32'(empty_a), 32'd1);
    check("midrst_full", 32'(full_a), 32'd0);
    check("midrst_ovf", 32'(ovf_a), 32'd0);
    check("midrst_unf", 32'(unf_a), 32'd0);
    @(negedge clk);
    en_a = 1'b0; op = NOP; rst = 1'b1;
    issue(0, PUSH, 32'hAA, 0);
    check("post_rst_depth", 32'(depth_a), 32'd1);
    check("post_rst_t", t_a, 32'hAA);
    check("post_rst_s", s_a, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ej32_dstack.md
# ej32_dstack

Parametrised data-stack engine for the eJ32 core, the successor to the fixed 32-bit stack logic inside the arithmetic unit. It holds TOS and NOS in registers and spills deeper entries into a parametrised register array. It executes one stack opcode per enabled cycle and exposes depth, full/empty status and sticky overflow/underflow flags. The AU and control unit drive it with an opcode plus a data word. Its TOS/NOS outputs feed the ALU and the memory bus.

## Interface
Parameters:
- DSZ, 32, data word width in bits (≥8)
- DEPTH, 64, total stack capacity including TOS and NOS (≥3)
- CW, $clog2(DEPTH+1), width of the depth counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- en  input  1  operation enable; when 0 no state changes
- op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 SWAP, 4 REPL, 5 POPREPL, 6 DUP, 7 OVER
- din  input  DSZ  data for PUSH/REPL/POPREPL
- clr_err  input  1  clears sticky error flags
- t_o  output  DSZ  top of stack (TOS)
- s_o  output  DSZ  next on stack (NOS)
- depth_o  output  CW  number of valid entries, 0..DEPTH
- empty_o  output  1  depth_o==0
- full_o  output  1  depth_o==DEPTH
- ovf_o  output  1  sticky overflow flag
- unf_o  output  1  sticky underflow flag
- err_o  output  1  pulse: current op rejected (combinational from op/en/depth)

## Operation
- Storage: t, s registers; array mem[0..DEPTH-3], pointer sp = number of entries in mem = max(depth-2,0). TOS valid when depth≥1; NOS valid when depth≥2.
- Legal ops (en=1):
  - PUSH: mem[sp]←s if depth≥2; s←t; t←din; depth+1
  - POP: t←s; s←mem[sp-1] if depth≥3; depth-1
  - SWAP: t↔s; depth unchanged
  - REPL: t←din; depth unchanged
  - POPREPL (binary ALU result): t←din; s←mem[sp-1] if depth≥3; depth-1
  - DUP: as PUSH with din=t
  - OVER: as PUSH with din=s
- Shift rule: any write to s from mem on a pop when depth≤2 loads 0 instead. Any invalid slot reads as 0.
- Rejection: illegal ops cause no state change, assert err_o the same cycle, and set the sticky flag on the clock edge.
  - Overflow (sets ovf): PUSH/DUP/OVER with depth==DEPTH.
  - Underflow (sets unf):
    - POP, REPL or DUP with depth==0
    - SWAP, OVER or POPREPL with depth<2
- NOP, or en=0: nothing changes; err_o=0.
- clr_err clears ovf/unf on the next edge. A simultaneous new error takes priority: the flag stays/becomes 1.
- Depth counter never wraps; legal ops cannot move it outside 0..DEPTH.

## Timing
- All outputs except err_o are registered. Results of an op issued in cycle n are visible on t_o/s_o/depth_o after the rising edge ending cycle n.
- Single-cycle throughput: back-to-back ops every cycle, each seeing the previous op's result.
- mem reads are combinational from sp-1 and writes are synchronous. A PUSH followed immediately by a POP returns the just-spilled value (no bypass hazard permitted).
- Reset (rst=0, any time, asynchronous):
  - t_o=0, s_o=0, depth_o=0, empty_o=1, full_o=0, ovf_o=0, unf_o=0
  - mem contents are not reset and are unreachable until rewritten
- Reset asserted mid-sequence aborts the in-flight op. No partial update is visible after release.
- First op is accepted on the first rising edge after rst deasserts.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 → t_o=0x33, s_o=0x22, depth_o=3. Then POP ×3 → t_o sequence 0x22, 0x11, 0; depth_o 2, 1, 0; empty_o=1.
- DEPTH=4 instance: PUSH 1,2,3,4 → full_o=1. PUSH 5 → err_o=1, ovf_o=1, t_o=4, depth_o=4. clr_err → ovf_o=0.
- Empty stack: POP → unf_o=1, depth_o=0. SWAP with depth=1 (t=7) → unf_o stays 1, t_o=7. clr_err together with POP on empty → unf_o remains 1.
- Stack 10,20,30 (t=30): SWAP → t=20, s=30. OVER → t=30, s=20, depth 4. POPREPL din=50 → t=50, s=30, depth 3. DUP → t=50, s=50, depth 4.
- PUSH then immediate POP every cycle for 100 cycles with random din at depth DEPTH-2 → t_o/s_o match a reference model each cycle.
- Assert rst during a PUSH with depth=5 → all outputs at reset values immediately. After release, PUSH 0xAA → depth_o=1, t_o=0xAA, s_o=0.
